// File: rtl/cpu_controller_if.sv
// Decoder-to-controller handshake and controller-to-datapath strobe bundle.
// master = instruction register/decoder side, slave = cpu_controller.
interface cpu_controller_if;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] ALU_op;
  logic       waiting;
  logic [1:0] reg_sel;
  logic       wb_sel;
  logic       w_en;
  logic       load_a;
  logic       load_b;
  logic       load_c;
  logic       load_s;
  logic       asel;
  logic       bsel;
  logic       illegal;

  modport master (
    output start, opcode, ALU_op,
    input  waiting, reg_sel, wb_sel, w_en, load_a, load_b, load_c, load_s,
           asel, bsel, illegal
  );

  modport slave (
    input  start, opcode, ALU_op,
    output waiting, reg_sel, wb_sel, w_en, load_a, load_b, load_c, load_s,
           asel, bsel, illegal
  );
endinterface

// File: rtl/cpu_controller.sv
// Moore control FSM sequencing MOV/ALU instructions through read, execute and write-back.
// Define CTRL_ILLEGAL_HALT_EN to trap unsupported encodings in a sticky HALT state.
module cpu_controller (
  input logic             clk,
  input logic             rst_n,
  cpu_controller_if.slave bus
);

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;

  localparam logic [1:0] SEL_RM = 2'b00;
  localparam logic [1:0] SEL_RD = 2'b01;
  localparam logic [1:0] SEL_RN = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_MOV_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WB
`ifdef CTRL_ILLEGAL_HALT_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic       waiting;
    logic [1:0] reg_sel;
    logic       wb_sel;
    logic       w_en;
    logic       load_a;
    logic       load_b;
    logic       load_c;
    logic       load_s;
    logic       asel;
`ifdef CTRL_ILLEGAL_HALT_EN
    logic       illegal;
`endif
  } ctrl_t;

  state_t     state_q;
  state_t     state_next;
  ctrl_t      ctrl_q;
  logic [2:0] op_q;
  logic [1:0] alu_q;

  function automatic state_t next_state(input state_t s, input logic start,
                                        input logic [2:0] op, input logic [1:0] alu);
    state_t n;
    n = S_WAIT;
    case (s)
      S_WAIT:    n = start ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (op == OP_MOV && alu == MOV_IMM)      n = S_MOV_IMM;
        else if (op == OP_MOV && alu == MOV_REG) n = S_GET_B;
        else if (op == OP_ALU)                   n = S_GET_A;
`ifdef CTRL_ILLEGAL_HALT_EN
        else                                     n = S_HALT;
`else
        else                                     n = S_WAIT;
`endif
      end
      S_MOV_IMM: n = S_WAIT;
      S_GET_A:   n = S_GET_B;
      S_GET_B:   n = S_EXEC;
      S_EXEC:    n = (op == OP_ALU && alu == ALU_CMP) ? S_WAIT : S_WB;
      S_WB:      n = S_WAIT;
`ifdef CTRL_ILLEGAL_HALT_EN
      S_HALT:    n = S_HALT;
`endif
      default:   n = S_WAIT;
    endcase
    return n;
  endfunction

  // Strobes for the state about to be entered; registering them keeps the outputs Moore and glitch-free.
  function automatic ctrl_t outputs_for(input state_t s, input logic [2:0] op,
                                        input logic [1:0] alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_WAIT:    c.waiting = 1'b1;
      S_MOV_IMM: begin c.reg_sel = SEL_RN; c.wb_sel = 1'b1; c.w_en = 1'b1; end
      S_GET_A:   begin c.reg_sel = SEL_RN; c.load_a = 1'b1; end
      S_GET_B:   begin c.reg_sel = SEL_RM; c.load_b = 1'b1; end
      S_EXEC: begin
        c.asel = (op == OP_MOV);
        if (op == OP_ALU && alu == ALU_CMP) begin
          c.load_s = 1'b1;
        end else begin
          c.load_c = 1'b1;
          c.load_s = (op == OP_ALU);
        end
      end
      S_WB:      begin c.reg_sel = SEL_RD; c.w_en = 1'b1; end
`ifdef CTRL_ILLEGAL_HALT_EN
      S_HALT:    c.illegal = 1'b1;
`endif
      default:   c = '0;
    endcase
    return c;
  endfunction

  // op_q/alu_q only change on acceptance, so they are already stable when EXEC is entered.
  assign state_next = next_state(state_q, bus.start, op_q, alu_q);

  // NOTE: async reset clears the registered strobes directly, so a pending w_en drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ctrl_q  <= '{waiting: 1'b1, default: '0};
      op_q    <= '0;
      alu_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_next;
      ctrl_q  <= outputs_for(state_next, op_q, alu_q);
      if (state_q == S_WAIT && bus.start) begin
        op_q  <= bus.opcode;
        alu_q <= bus.ALU_op;
      end
    end
  end

  assign bus.waiting = ctrl_q.waiting;
  assign bus.reg_sel = ctrl_q.reg_sel;
  assign bus.wb_sel  = ctrl_q.wb_sel;
  assign bus.w_en    = ctrl_q.w_en;
  assign bus.load_a  = ctrl_q.load_a;
  assign bus.load_b  = ctrl_q.load_b;
  assign bus.load_c  = ctrl_q.load_c;
  assign bus.load_s  = ctrl_q.load_s;
  assign bus.asel    = ctrl_q.asel;
  assign bus.bsel    = 1'b0;
`ifdef CTRL_ILLEGAL_HALT_EN
  assign bus.illegal = ctrl_q.illegal;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller; expected strobe vectors are hand-derived per state.
// Output vector layout: {waiting, reg_sel[1:0], wb_sel, w_en, load_a, load_b, load_c, load_s, asel, bsel, illegal}.
module tb_cpu_controller;

  localparam logic [11:0] E_WAIT    = 12'b1_00_0_0_0_0_0_0_0_0_0;
  localparam logic [11:0] E_DEC     = 12'b0_00_0_0_0_0_0_0_0_0_0;
  localparam logic [11:0] E_MOV_IMM = 12'b0_10_1_1_0_0_0_0_0_0_0;
  localparam logic [11:0] E_GET_A   = 12'b0_10_0_0_1_0_0_0_0_0_0;
  localparam logic [11:0] E_GET_B   = 12'b0_00_0_0_0_1_0_0_0_0_0;
  localparam logic [11:0] E_EX_ALU  = 12'b0_00_0_0_0_0_1_1_0_0_0;
  localparam logic [11:0] E_EX_CMP  = 12'b0_00_0_0_0_0_0_1_0_0_0;
  localparam logic [11:0] E_EX_MOV  = 12'b0_00_0_0_0_0_1_0_1_0_0;
  localparam logic [11:0] E_WB      = 12'b0_01_0_1_0_0_0_0_0_0_0;
  localparam logic [11:0] E_HALT    = 12'b0_00_0_0_0_0_0_0_0_0_1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [11:0] seq [0:7];
  int          seq_len;
  logic [11:0] obs;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.waiting, bus.reg_sel, bus.wb_sel, bus.w_en, bus.load_a, bus.load_b,
                bus.load_c, bus.load_s, bus.asel, bus.bsel, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic load_seq(input int n, input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] d,
                          input logic [11:0] e, input logic [11:0] f);
    seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d; seq[4] = e; seq[5] = f;
    seq[6] = '0; seq[7] = '0;
    seq_len = n;
  endtask

  // Called at posedge+1 in WAIT: launches one instruction, then rewrites the IR after acceptance.
  task automatic run_seq(input string name, input logic [2:0] op, input logic [1:0] alu,
                         input logic [2:0] op_after, input logic [1:0] alu_after);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.ALU_op = alu;
    for (int i = 0; i < seq_len; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.start  = 1'b0;
        bus.opcode = op_after;
        bus.ALU_op = alu_after;
      end
      check($sformatf("%s_%0d", name, i), obs, seq[i]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = 3'b000;
    bus.ALU_op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", obs, E_WAIT);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_wait", obs, E_WAIT);

    load_seq(3, E_DEC, E_MOV_IMM, E_WAIT, '0, '0, '0);
    run_seq("mov_imm", 3'b110, 2'b10, 3'b101, 2'b00);

    load_seq(6, E_DEC, E_GET_A, E_GET_B, E_EX_ALU, E_WB, E_WAIT);
    run_seq("add", 3'b101, 2'b00, 3'b000, 2'b00);

    load_seq(5, E_DEC, E_GET_A, E_GET_B, E_EX_CMP, E_WAIT, '0);
    run_seq("cmp", 3'b101, 2'b01, 3'b110, 2'b10);

    load_seq(5, E_DEC, E_GET_B, E_EX_MOV, E_WB, E_WAIT, '0);
    run_seq("mov_reg", 3'b110, 2'b00, 3'b101, 2'b01);

    load_seq(6, E_DEC, E_GET_A, E_GET_B, E_EX_ALU, E_WB, E_WAIT);
    run_seq("mvn", 3'b101, 2'b11, 3'b111, 2'b11);

    // start held high: WAIT lasts one cycle, then the next instruction is taken.
    bus.start  = 1'b1;
    bus.opcode = 3'b110;
    bus.ALU_op = 2'b10;
    @(posedge clk); #1; check("b2b_dec0", obs, E_DEC);
    @(posedge clk); #1; check("b2b_mov0", obs, E_MOV_IMM);
    @(posedge clk); #1; check("b2b_wait", obs, E_WAIT);
    @(posedge clk); #1; check("b2b_dec1", obs, E_DEC);
    bus.start = 1'b0;
    @(posedge clk); #1; check("b2b_mov1", obs, E_MOV_IMM);
    @(posedge clk); #1; check("b2b_done", obs, E_WAIT);

    // Asynchronous reset in the middle of GET_A.
    bus.start  = 1'b1;
    bus.opcode = 3'b101;
    bus.ALU_op = 2'b00;
    @(posedge clk); #1; bus.start = 1'b0; check("abort_dec", obs, E_DEC);
    @(posedge clk); #1; check("abort_get_a", obs, E_GET_A);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", obs, E_WAIT);
    check("abort_op_q", {9'b0, dut.op_q}, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1; check("abort_release", obs, E_WAIT);

`ifdef CTRL_ILLEGAL_HALT_EN
    load_seq(3, E_DEC, E_HALT, E_HALT, '0, '0, '0);
    run_seq("illegal", 3'b111, 2'b00, 3'b110, 2'b10);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      check($sformatf("halt_sticky_%0d", i), obs, E_HALT);
    end
    #2 rst_n = 1'b0;
    #1;
    check("halt_reset", obs, E_WAIT);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
`else
    load_seq(2, E_DEC, E_WAIT, '0, '0, '0, '0);
    run_seq("illegal", 3'b111, 2'b00, 3'b110, 2'b10);
    load_seq(2, E_DEC, E_WAIT, '0, '0, '0, '0);
    run_seq("mov_bad", 3'b110, 2'b11, 3'b000, 2'b00);
`endif

    load_seq(3, E_DEC, E_MOV_IMM, E_WAIT, '0, '0, '0);
    run_seq("recover", 3'b110, 2'b10, 3'b000, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
